// File: rtl/irq_pkg.sv
// irq_pkg: shared encodings for the interrupt controller.
// FSM states, cause codes, default ISR vectors and the priority picker.
package irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_TIMER = 2'b01;
  localparam logic [1:0] CAUSE_KEY   = 2'b10;

  localparam logic [31:0] VEC_TIMER_DEF = 32'd9636;
  localparam logic [31:0] VEC_KEY_DEF   = 32'd9700;

  // Timer outranks keyboard.
  function automatic logic [1:0] pick_cause(
    input logic [1:0] act
  );
    logic [1:0] c;
    c = CAUSE_NONE;
    if (act[0]) begin
      c = CAUSE_TIMER;
    end else if (act[1]) begin
      c = CAUSE_KEY;
    end
    return c;
  endfunction

endpackage

// File: rtl/irq_timer.sv
// irq_timer: free-running tick divider, counts 0..DIV-1 while enabled.
// tc is high during the cycle the counter sits at DIV-1 with en=1.
module irq_timer #(
  parameter int unsigned DIV = 33554432
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic tc
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = tc ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/irq_controller.sv
// irq_controller: timer/keyboard interrupt arbiter with IDLE/REQ/SERVICE flow.
// Define KEYBOARD_IRQ_EN to include the keyboard source.
module irq_controller
  import irq_pkg::*;
#(
  parameter int unsigned TIMER_DIV = 33554432,
  parameter logic [31:0] VEC_TIMER = VEC_TIMER_DEF,
  parameter logic [31:0] VEC_KEY   = VEC_KEY_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        irq_ack,
  input  logic        eoi,
  input  logic        timer_en,
  input  logic [1:0]  mask,
  input  logic        key_sample,
  output logic        irq_req,
  output logic [31:0] irq_vector,
  output logic [31:0] saved_pc,
  output logic [1:0]  irq_cause,
  output logic        in_service
);

  irq_state_e  state_q;
  irq_state_e  state_d;
  logic [1:0]  pend_q;
  logic [1:0]  pend_d;
  logic [1:0]  pend_set;
  logic [1:0]  pend_clr;
  logic [1:0]  pend_act;
  logic [1:0]  mask_eff;
  logic [1:0]  cause_q;
  logic [1:0]  cause_d;
  logic [1:0]  next_cause;
  logic [31:0] vec_q;
  logic [31:0] vec_d;
  logic [31:0] spc_q;
  logic [31:0] spc_d;
  logic        tick;
  logic        key_evt;

  irq_timer #(
    .DIV(TIMER_DIV)
  ) u_timer (
    .clock(clock),
    .reset(reset),
    .en   (timer_en),
    .tc   (tick)
  );

`ifdef KEYBOARD_IRQ_EN
  logic [2:0] ksync_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      ksync_q <= '0;
    end else begin
      ksync_q <= {ksync_q[1:0], key_sample};
    end
  end

  // ksync_q[1] is the synchroniser output, ksync_q[2] its last value
  assign key_evt  = ksync_q[2] ^ ksync_q[1];
  assign mask_eff = mask;
`else
  logic unused_key;

  assign unused_key = key_sample ^ mask[1];
  assign key_evt    = 1'b0;
  assign mask_eff   = {1'b1, mask[0]};
`endif

  assign pend_set   = {key_evt, tick};
  assign pend_act   = pend_q & ~mask_eff;
  assign next_cause = pick_cause(pend_act);

  // Cause codes are one-hot over the pending bits they serve.
  always_comb begin
    pend_clr = '0;
    if (state_q == ST_REQ && irq_ack) begin
      pend_clr = cause_q;
    end
    pend_d = (pend_q & ~pend_clr) | pend_set;
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    vec_d   = vec_q;
    spc_d   = spc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|pend_act) begin
          state_d = ST_REQ;
          cause_d = next_cause;
          vec_d   = (next_cause == CAUSE_TIMER) ? VEC_TIMER : VEC_KEY;
        end
      end
      ST_REQ: begin
        if (irq_ack) begin
          state_d = ST_SERVICE;
          spc_d   = pc;
        end
      end
      ST_SERVICE: begin
        if (eoi) begin
          state_d = ST_IDLE;
          cause_d = CAUSE_NONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cause_d = CAUSE_NONE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      cause_q <= CAUSE_NONE;
      vec_q   <= '0;
      spc_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cause_q <= cause_d;
      vec_q   <= vec_d;
      spc_q   <= spc_d;
    end
  end

  assign irq_req    = (state_q == ST_REQ);
  assign in_service = (state_q == ST_SERVICE);
  assign irq_cause  = cause_q;
  assign irq_vector = vec_q;
  assign saved_pc   = spc_q;

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed scenarios plus randomized run against a
// cycle-level reference model of the interrupt rules (TIMER_DIV=8).
module tb_irq_controller;

  localparam int DIV = 8;
  localparam logic [31:0] VT = 32'd9636;
  localparam logic [31:0] VK = 32'd9700;
`ifdef KEYBOARD_IRQ_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic [31:0] pc;
  logic        irq_ack;
  logic        eoi;
  logic        timer_en;
  logic [1:0]  mask;
  logic        key_sample;
  logic        irq_req;
  logic [31:0] irq_vector;
  logic [31:0] saved_pc;
  logic [1:0]  irq_cause;
  logic        in_service;

  int checks = 0;
  int failures = 0;

  // reference model
  int        cyc = 0;
  int        m_cnt = 0;
  bit [1:0]  m_pend = 0;
  bit        m_req = 0;
  bit        m_svc = 0;
  bit [1:0]  m_cause = 0;
  bit [31:0] m_vec = 0;
  bit [31:0] m_spc = 0;
  bit        m_kprev = 0;
  int        kq[$];

  irq_controller #(
    .TIMER_DIV(DIV),
    .VEC_TIMER(VT),
    .VEC_KEY  (VK)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .pc        (pc),
    .irq_ack   (irq_ack),
    .eoi       (eoi),
    .timer_en  (timer_en),
    .mask      (mask),
    .key_sample(key_sample),
    .irq_req   (irq_req),
    .irq_vector(irq_vector),
    .saved_pc  (saved_pc),
    .irq_cause (irq_cause),
    .in_service(in_service)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One clock edge: advance the model with the inputs seen at the edge.
  task automatic step();
    bit       tick;
    bit [1:0] setv;
    bit [1:0] clrv;
    bit [1:0] act;
    bit [1:0] meff;
    @(posedge clock);
    if (reset) begin
      m_cnt = 0; m_pend = 0; m_req = 0; m_svc = 0;
      m_cause = 0; m_vec = 0; m_spc = 0; m_kprev = 0;
      kq.delete();
    end else begin
      tick = timer_en && (m_cnt == DIV - 1);
      if (timer_en) m_cnt = (m_cnt + 1) % DIV;
      setv = {1'b0, tick};
      if (KEY_EN) begin
        while (kq.size() > 0 && kq[0] == cyc) begin
          setv[1] = 1'b1;
          void'(kq.pop_front());
        end
        if (key_sample != m_kprev) kq.push_back(cyc + 2);
        m_kprev = key_sample;
      end
      meff = KEY_EN ? mask : {1'b1, mask[0]};
      clrv = 0;
      if (!m_req && !m_svc) begin
        act = m_pend & ~meff;
        if (act != 0) begin
          m_req   = 1;
          m_cause = act[0] ? 2'b01 : 2'b10;
          m_vec   = act[0] ? VT : VK;
        end
      end else if (m_req) begin
        if (irq_ack) begin
          m_req = 0;
          m_svc = 1;
          m_spc = pc;
          if (m_cause == 2'b01) clrv[0] = 1'b1;
          else clrv[1] = 1'b1;
        end
      end else if (eoi) begin
        m_svc   = 0;
        m_cause = 0;
      end
      m_pend = (m_pend & ~clrv) | setv;
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1; irq_ack = 0; eoi = 0;
    step();
    step();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; timer_en = 1; irq_ack = 1; eoi = 1; mask = 0;
    pc = 32'hDEAD_BEEF;
    step();
    step();
    checks++;
    if (irq_req !== 1'b0) begin
      failures++; $display("FAIL rst_req got=%0b want=0", irq_req);
    end
    checks++;
    if (irq_cause !== 2'b00) begin
      failures++; $display("FAIL rst_cause got=%0b want=00", irq_cause);
    end
    checks++;
    if (irq_vector !== 32'd0) begin
      failures++; $display("FAIL rst_vec got=%0h want=0", irq_vector);
    end
    checks++;
    if (saved_pc !== 32'd0) begin
      failures++; $display("FAIL rst_spc got=%0h want=0", saved_pc);
    end
    checks++;
    if (in_service !== 1'b0) begin
      failures++; $display("FAIL rst_svc got=%0b want=0", in_service);
    end
    irq_ack = 0; eoi = 0;
  endtask

  task automatic test_timer_first();
    reset = 0; timer_en = 1; mask = 2'b00;
    for (int k = 1; k <= 9; k++) begin
      step();
      checks++;
      if (irq_req !== (k == 9)) begin
        failures++;
        $display("FAIL tick_req k=%0d got=%0b want=%0b", k, irq_req, k == 9);
      end
    end
    checks++;
    if (irq_vector !== VT) begin
      failures++; $display("FAIL tick_vec got=%0d want=%0d", irq_vector, VT);
    end
    checks++;
    if (irq_cause !== 2'b01) begin
      failures++; $display("FAIL tick_cause got=%0b want=01", irq_cause);
    end
  endtask

  task automatic test_ack_eoi();
    pc = 32'h100; irq_ack = 1;
    step();
    checks++;
    if (saved_pc !== 32'h100) begin
      failures++; $display("FAIL ack_spc got=%0h want=100", saved_pc);
    end
    checks++;
    if (in_service !== 1'b1 || irq_req !== 1'b0) begin
      failures++;
      $display("FAIL ack_state got svc=%0b req=%0b want svc=1 req=0",
               in_service, irq_req);
    end
    pc = 32'h200;
    step();
    checks++;
    if (saved_pc !== 32'h100 || in_service !== 1'b1) begin
      failures++;
      $display("FAIL ack_ignored got spc=%0h svc=%0b want spc=100 svc=1",
               saved_pc, in_service);
    end
    irq_ack = 0; eoi = 1;
    step();
    eoi = 0;
    checks++;
    if (in_service !== 1'b0 || irq_cause !== 2'b00) begin
      failures++;
      $display("FAIL eoi_state got svc=%0b cause=%0b want svc=0 cause=00",
               in_service, irq_cause);
    end
    checks++;
    if (saved_pc !== 32'h100) begin
      failures++; $display("FAIL eoi_spc got=%0h want=100", saved_pc);
    end
  endtask

  task automatic test_mask();
    do_reset();
    mask = 2'b01; timer_en = 1;
    for (int k = 0; k < 20; k++) begin
      step();
      checks++;
      if (irq_req !== 1'b0) begin
        failures++; $display("FAIL mask_hold k=%0d got=%0b want=0", k, irq_req);
      end
    end
    mask = 2'b00; timer_en = 0;
    step();
    checks++;
    if (irq_req !== 1'b1 || irq_cause !== 2'b01) begin
      failures++;
      $display("FAIL mask_clear got req=%0b cause=%0b want req=1 cause=01",
               irq_req, irq_cause);
    end
  endtask

  task automatic test_reset_in_service();
    do_reset();
    timer_en = 1; mask = 0;
    repeat (9) step();
    irq_ack = 1; pc = 32'h44;
    step();
    irq_ack = 0;
    checks++;
    if (in_service !== 1'b1) begin
      failures++; $display("FAIL svc_entry got=%0b want=1", in_service);
    end
    reset = 1;
    step();
    checks++;
    if ({irq_req, in_service, irq_cause, irq_vector, saved_pc} !== '0) begin
      failures++;
      $display("FAIL svc_reset got req=%0b svc=%0b cause=%0b vec=%0h spc=%0h want all 0",
               irq_req, in_service, irq_cause, irq_vector, saved_pc);
    end
    reset = 0;
    for (int k = 1; k <= 9; k++) begin
      step();
      checks++;
      if (irq_req !== (k == 9)) begin
        failures++;
        $display("FAIL post_rst_req k=%0d got=%0b want=%0b", k, irq_req, k == 9);
      end
    end
    irq_ack = 1;
    step();
    irq_ack = 0; eoi = 1;
    step();
    eoi = 0;
  endtask

`ifdef KEYBOARD_IRQ_EN
  task automatic test_collision();
    do_reset();
    timer_en = 1; mask = 0; key_sample = 0;
    step(); step();
    repeat (7) step();
    key_sample = 1;
    step();
    timer_en = 0;
    step();
    checks++;
    if (irq_req !== 1'b1 || irq_cause !== 2'b01 || irq_vector !== VT) begin
      failures++;
      $display("FAIL coll_first got req=%0b cause=%0b vec=%0d want 1/01/%0d",
               irq_req, irq_cause, irq_vector, VT);
    end
    irq_ack = 1;
    step();
    irq_ack = 0; eoi = 1;
    step();
    eoi = 0;
    step();
    checks++;
    if (irq_req !== 1'b1 || irq_cause !== 2'b10 || irq_vector !== VK) begin
      failures++;
      $display("FAIL coll_second got req=%0b cause=%0b vec=%0d want 1/10/%0d",
               irq_req, irq_cause, irq_vector, VK);
    end
    timer_en = 1;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (irq_req !== 1'b1 || irq_cause !== 2'b10 || irq_vector !== VK) begin
        failures++;
        $display("FAIL req_frozen k=%0d got req=%0b cause=%0b vec=%0d",
                 k, irq_req, irq_cause, irq_vector);
      end
    end
    timer_en = 0; irq_ack = 1;
    step();
    irq_ack = 0; eoi = 1;
    step();
    eoi = 0;
    step();
    checks++;
    if (irq_req !== 1'b1 || irq_cause !== 2'b01) begin
      failures++;
      $display("FAIL accum_timer got req=%0b cause=%0b want 1/01",
               irq_req, irq_cause);
    end
  endtask
`else
  task automatic test_key_disabled();
    do_reset();
    timer_en = 0; mask = 2'b00;
    for (int t = 0; t < 3; t++) begin
      key_sample = ~key_sample;
      repeat (3) begin
        step();
        checks++;
        if (irq_req !== 1'b0) begin
          failures++; $display("FAIL key_off got=%0b want=0", irq_req);
        end
      end
    end
    repeat (6) begin
      step();
      checks++;
      if (irq_req !== 1'b0) begin
        failures++; $display("FAIL key_off_tail got=%0b want=0", irq_req);
      end
    end
    mask = 2'b10; timer_en = 1;
    repeat (9) step();
    checks++;
    if (irq_req !== 1'b1 || irq_cause !== 2'b01) begin
      failures++;
      $display("FAIL mask1_noeffect got req=%0b cause=%0b want 1/01",
               irq_req, irq_cause);
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      reset    = ($urandom_range(199) == 0);
      timer_en = ($urandom_range(7) != 0);
      if ($urandom_range(19) == 0) mask = 2'($urandom_range(3));
      irq_ack  = ($urandom_range(2) == 0);
      eoi      = ($urandom_range(2) == 0);
      if ($urandom_range(5) == 0) key_sample = ~key_sample;
      pc       = $urandom;
      step();
      checks++;
      if (irq_req !== m_req || in_service !== m_svc) begin
        failures++;
        $display("FAIL rnd_state k=%0d got req=%0b svc=%0b want req=%0b svc=%0b",
                 k, irq_req, in_service, m_req, m_svc);
      end
      checks++;
      if (irq_cause !== m_cause) begin
        failures++;
        $display("FAIL rnd_cause k=%0d got=%0b want=%0b", k, irq_cause, m_cause);
      end
      checks++;
      if (irq_vector !== m_vec) begin
        failures++;
        $display("FAIL rnd_vec k=%0d got=%0d want=%0d", k, irq_vector, m_vec);
      end
      checks++;
      if (saved_pc !== m_spc) begin
        failures++;
        $display("FAIL rnd_spc k=%0d got=%0h want=%0h", k, saved_pc, m_spc);
      end
    end
    reset = 0; irq_ack = 0; eoi = 0;
  endtask

  initial begin
    reset = 1; pc = 0; irq_ack = 0; eoi = 0;
    timer_en = 0; mask = 0; key_sample = 0;
    test_reset();
    test_timer_first();
    test_ack_eoi();
    test_mask();
    test_reset_in_service();
`ifdef KEYBOARD_IRQ_EN
    test_collision();
`else
    test_key_disabled();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
